// File: rtl/inst_fetch.sv
// Instruction-fetch stage: owns the PC, reads the async ROM and fills
// the IF/ID register under a valid/ready handshake toward decode.
module inst_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          ROM_DEPTH = 20,
    parameter int          ADDR_W    = 5
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [31:0]       rom_inst,
    input  logic              id_ready,
    input  logic              redirect,
    input  logic [31:0]       redirect_pc,
    output logic              if_valid,
    output logic [31:0]       if_inst,
    output logic [31:0]       if_pc,
    output logic              fetch_err,
    output logic [31:0]       fetch_cnt
);

    typedef enum logic {
        RUN,
        HALT
    } state_t;

    localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(ROM_DEPTH);

    state_t      state;
    logic [31:0] pc;
    logic        fire;
    logic        bad;
    logic        handoff;
    logic        do_fetch;
    logic        do_fault;

    assign rom_addr = pc[ADDR_W+1:2];

    assign bad = (pc[1:0] != 2'b00)
              || ({1'b0, rom_addr} >= DEPTH)
              || (pc[31:ADDR_W+2] != '0);

    assign fire     = (state == RUN) && (!if_valid || id_ready);
    assign handoff  = if_valid && id_ready && !redirect;
    // A redirect wins over any fetch, so a wrong-path bad pc never faults.
    assign do_fetch = !redirect && fire && !bad;
    assign do_fault = !redirect && fire && bad;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            pc        <= RESET_PC;
            if_valid  <= 1'b0;
            if_inst   <= '0;
            if_pc     <= '0;
            fetch_err <= 1'b0;
            fetch_cnt <= '0;
        end else begin
            if (handoff) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
            unique case (1'b1)
                redirect: begin
                    pc        <= redirect_pc;
                    if_valid  <= 1'b0;
                    state     <= RUN;
                    fetch_err <= 1'b0;
                end
                do_fetch: begin
                    if_inst  <= rom_inst;
                    if_pc    <= pc;
                    if_valid <= 1'b1;
                    pc       <= pc + 32'd4;
                end
                do_fault: begin
                    if_valid  <= 1'b0;
                    state     <= HALT;
                    fetch_err <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction-fetch stage for the single-issue MIPS teaching core. It owns the PC and drives the 5-bit word address of the asynchronous instruction ROM. It captures the returned 32-bit instruction into an IF/ID pipeline register with a valid/ready handshake toward decode. It also handles decode-issued redirects (branch/jump), detects fetches outside the populated ROM, and counts delivered instructions.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- ROM_DEPTH, 20, number of populated ROM words; word index >= ROM_DEPTH is an error
- ADDR_W, 5, ROM word-address width

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- rom_addr  out  ADDR_W  ROM word address = pc[ADDR_W+1:2], combinational from pc
- rom_inst  in  32  ROM read data, valid in the same cycle as rom_addr
- id_ready  in  1  decode can accept the IF/ID contents this cycle
- redirect  in  1  decode requests PC change (taken branch/jump)
- redirect_pc  in  32  target PC when redirect=1
- if_valid  out  1  IF/ID register holds an instruction for decode
- if_inst  out  32  registered instruction
- if_pc  out  32  byte PC of if_inst
- fetch_err  out  1  high while in HALT (bad fetch address)
- fetch_cnt  out  32  instructions handed to decode

## Operation
- States: RUN, HALT. Reset puts the block in RUN.
- Reset values: pc=RESET_PC, if_valid=0, if_inst=0, if_pc=0, fetch_err=0, fetch_cnt=0. rom_addr therefore = RESET_PC[6:2].
- fire = RUN && (!if_valid || id_ready): the IF/ID slot is free or is being consumed this cycle.
- bad = pc[1:0]!=0 || pc[ADDR_W+1:2] >= ROM_DEPTH || pc[31:ADDR_W+2]!=0.
- Priority per cycle: rst > redirect > fire > hold.
- Redirect (either state):
  - pc <= redirect_pc; if_valid <= 0, squashing the IF/ID contents regardless of id_ready.
  - State <= RUN; fetch_err <= 0.
  - No fetch occurs that cycle.
- RUN, fire, !bad: if_inst <= rom_inst, if_pc <= pc, if_valid <= 1, pc <= pc+4 (mod 2^32).
- RUN, fire, bad: if_valid <= 0, state <= HALT, fetch_err <= 1. pc holds the faulting address and is not loaded into if_pc.
- RUN, !fire: all registers hold; rom_addr stays stable.
- HALT: no fetch; pc holds.
  - if_valid is already 0, because entry to HALT requires fire, which consumes or finds an empty slot.
  - Leaves HALT only by redirect or rst.
- fetch_cnt increments by 1 when if_valid && id_ready && !redirect. Wraps 2^32-1 -> 0.
- A redirect coincident with bad suppresses the error (wrong-path fetch).

## Timing
- ROM path is combinational: fetch-to-if_valid latency is 1 cycle.
- Steady state with id_ready=1: one instruction per cycle; if_pc advances by 4 each cycle.
- Redirect asserted in cycle N:
  - N+1: pc=redirect_pc, if_valid=0.
  - N+2: if_valid=1 with the target instruction, if target is good.
- Stall: while if_valid=1 && id_ready=0, if_inst/if_pc/if_valid and pc are frozen.
- Error: bad pc seen with fire in cycle N -> fetch_err=1 and if_valid=0 from N+1.
- rst mid-operation: the next edge applies the reset values regardless of redirect, stall or HALT.

## Test plan
- Reset, then id_ready=1 for 3 cycles -> if_inst/if_pc = 24010001/0x00, 00011100/0x04, 00411821/0x08 on consecutive cycles; fetch_cnt=3 after the third handoff.
- id_ready=0 for 3 cycles while if_pc=0x08 -> if_inst stays 00411821, rom_addr stays 3. Raise id_ready -> 00022082/0x0C next cycle.
- Redirect to 0x34 with the IF/ID slot valid:
  - Next cycle: if_valid=0.
  - Following cycle: if_inst=8C2A0013, if_pc=0x34.
  - fetch_cnt does not count the squashed instruction.
- Run sequentially past 0x4C (08000000, no redirect) -> pc=0x50, index 20 -> fetch_err=1, if_valid=0, pc held 0x50. Redirect 0x00 -> fetch_err=0, then 24010001 delivered.
- Misaligned redirect 0x06 -> fetch_err=1 one cycle after pc=0x06. Redirect 0x00 in the same cycle as a bad fetch -> no error.
- Assert rst while in HALT and while stalled with if_valid=1 -> next cycle all outputs at reset values, rom_addr=0.
